// File: rtl/bsg_counter_clear_up_down_saturating_array_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : bsg_counter_clear_up_down_saturating_array_if                 |
// | Purpose  : Control/status bundle for the saturating counter array.       |
// |            clip_o/irq_o exist only with BSG_COUNTER_SAT_ARRAY_CLIP_EN.   |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
interface bsg_counter_clear_up_down_saturating_array_if #(
  parameter int els_p        = 1,
  parameter int step_width_p = 1,
  parameter int ptr_width_lp = 1
);
  logic [els_p-1:0]              clear_i;
  logic [els_p-1:0]              up_i;
  logic [els_p*step_width_p-1:0] up_step_i;
  logic [els_p-1:0]              down_i;
  logic [els_p*ptr_width_lp-1:0] count_o;
  logic [els_p-1:0]              at_thresh_o;
`ifdef BSG_COUNTER_SAT_ARRAY_CLIP_EN
  logic [els_p-1:0]              clip_o;
  logic                          irq_o;

  modport master (output clear_i, up_i, up_step_i, down_i,
                  input  count_o, at_thresh_o, clip_o, irq_o);
  modport slave  (input  clear_i, up_i, up_step_i, down_i,
                  output count_o, at_thresh_o, clip_o, irq_o);
`else
  modport master (output clear_i, up_i, up_step_i, down_i,
                  input  count_o, at_thresh_o);
  modport slave  (input  clear_i, up_i, up_step_i, down_i,
                  output count_o, at_thresh_o);
`endif
endinterface
`default_nettype wire

// File: rtl/bsg_counter_clear_up_down_saturating_array.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : bsg_counter_clear_up_down_saturating_array                    |
// | Purpose  : Bank of independent saturating counters with clear, variable  |
// |            up step and unit down, plus registered threshold flags.       |
// |            Define BSG_COUNTER_SAT_ARRAY_CLIP_EN for sticky clip flags     |
// |            and an OR-reduced interrupt.                                  |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module bsg_counter_clear_up_down_saturating_array #(
  parameter int els_p        = 1,
  parameter int max_val_p    = 1,
  parameter int step_width_p = 1,
  parameter int thresh_val_p = max_val_p,
  parameter int init_val_p   = 0
) (
  input wire logic clk_i,
  input wire logic reset_n_i,
  bsg_counter_clear_up_down_saturating_array_if.slave bus
);

  localparam int ptr_width_lp = ($clog2(max_val_p + 1) == 0) ? 1 : $clog2(max_val_p + 1);
  // Signed working width: holds base + max step, and -1 for a down on zero.
  localparam int c_dw         = ptr_width_lp + step_width_p + 1;

  localparam logic signed [c_dw-1:0]         c_max_s      = c_dw'(max_val_p);
  localparam logic        [ptr_width_lp-1:0] c_max        = ptr_width_lp'(max_val_p);
  localparam logic        [ptr_width_lp-1:0] c_init       = ptr_width_lp'(init_val_p);
  localparam logic        [ptr_width_lp-1:0] c_thresh     = ptr_width_lp'(thresh_val_p);
  localparam logic                           c_init_above = (init_val_p >= thresh_val_p);

  // Illegal configurations stop elaboration.
  if (els_p < 1) begin : g_err_els
    $error("els_p must be at least 1");
  end
  if (init_val_p > max_val_p) begin : g_err_init
    $error("init_val_p exceeds max_val_p");
  end
  if (thresh_val_p > max_val_p) begin : g_err_thresh
    $error("thresh_val_p exceeds max_val_p");
  end

`ifdef BSG_COUNTER_SAT_ARRAY_CLIP_EN
  logic [els_p-1:0] w_clip_next;
  logic             r_irq;
`endif

  for (genvar i = 0; i < els_p; i++) begin : g_ch
    logic        [ptr_width_lp-1:0] r_count;
    logic                           r_thresh;
    logic        [ptr_width_lp-1:0] w_base;
    logic        [step_width_p-1:0] w_step;
    logic signed [c_dw-1:0]         w_delta;
    logic signed [c_dw-1:0]         w_sum;
    logic                           w_clip_hi;
    logic                           w_clip_lo;
    logic        [ptr_width_lp-1:0] w_next;

    // Clear zeroes the base before the net up/down delta is applied.
    assign w_step    = bus.up_step_i[i*step_width_p +: step_width_p];
    assign w_base    = bus.clear_i[i] ? '0 : r_count;
    assign w_delta   = (bus.up_i[i]   ? c_dw'(w_step) : '0)
                     - (bus.down_i[i] ? c_dw'(1)      : '0);
    assign w_sum     = $signed(c_dw'(w_base)) + w_delta;
    assign w_clip_hi = (w_sum > c_max_s);
    assign w_clip_lo = w_sum[c_dw-1];
    assign w_next    = w_clip_hi ? c_max :
                       w_clip_lo ? '0    : w_sum[ptr_width_lp-1:0];

    // Count and threshold flag both come from next, so they always agree.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
        r_count  <= c_init;
        r_thresh <= c_init_above;
      end else begin
        r_count  <= w_next;
        r_thresh <= (w_next >= c_thresh);
      end
    end

    assign bus.count_o[i*ptr_width_lp +: ptr_width_lp] = r_count;
    assign bus.at_thresh_o[i]                          = r_thresh;

`ifdef BSG_COUNTER_SAT_ARRAY_CLIP_EN
    logic r_clip;

    // A clip in the same cycle as a clear wins, leaving the flag set.
    assign w_clip_next[i] = w_clip_hi | w_clip_lo | (r_clip & ~bus.clear_i[i]);

    // Sticky clip flag.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
        r_clip <= 1'b0;
      end else begin
        r_clip <= w_clip_next[i];
      end
    end

    assign bus.clip_o[i] = r_clip;
`endif
  end

`ifdef BSG_COUNTER_SAT_ARRAY_CLIP_EN
  // Interrupt is built from next-state flags so it rises with clip_o.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_irq <= 1'b0;
    end else begin
      r_irq <= |w_clip_next;
    end
  end

  assign bus.irq_o = r_irq;
`endif

endmodule
`default_nettype wire

// File: tb/tb_bsg_counter_clear_up_down_saturating_array.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_bsg_counter_clear_up_down_saturating_array                 |
// | Purpose  : Directed self-checking bench for the saturating counter array |
// |            (els=4, max=10, init=9, thresh=8, step width 2).              |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module tb_bsg_counter_clear_up_down_saturating_array;

  logic clk;
  logic reset_n;
  int   checks = 0;
  int   errors = 0;

  bsg_counter_clear_up_down_saturating_array_if #(
    .els_p(4), .step_width_p(2), .ptr_width_lp(4)
  ) bus ();

  bsg_counter_clear_up_down_saturating_array #(
    .els_p(4), .max_val_p(10), .step_width_p(2), .thresh_val_p(8), .init_val_p(9)
  ) dut (
    .clk_i    (clk),
    .reset_n_i(reset_n),
    .bus      (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_flags(input string tag, input logic [3:0] clip, input logic irq);
`ifdef BSG_COUNTER_SAT_ARRAY_CLIP_EN
    chk({tag, ".clip"}, 32'(bus.clip_o), 32'(clip));
    chk({tag, ".irq"},  32'(bus.irq_o),  32'(irq));
`else
    if (clip === 4'bxxxx && irq === 1'bx) $display("unreachable");
`endif
  endtask

  // Drive one cycle of inputs (step packed {s3,s2,s1,s0}), then check after the edge.
  task automatic cyc(input string tag, input logic [3:0] clr, input logic [3:0] up,
                     input logic [7:0] step, input logic [3:0] dn,
                     input logic [15:0] e_cnt, input logic [3:0] e_th,
                     input logic [3:0] e_clip, input logic e_irq);
    bus.clear_i   = clr;
    bus.up_i      = up;
    bus.up_step_i = step;
    bus.down_i    = dn;
    @(posedge clk);
    #1;
    chk({tag, ".count"},  32'(bus.count_o),     32'(e_cnt));
    chk({tag, ".thresh"}, 32'(bus.at_thresh_o), 32'(e_th));
    chk_flags(tag, e_clip, e_irq);
  endtask

  initial begin
    reset_n       = 1'b0;
    bus.clear_i   = '0;
    bus.up_i      = '0;
    bus.up_step_i = '0;
    bus.down_i    = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    chk("reset.count",  32'(bus.count_o),     32'h9999);
    chk("reset.thresh", 32'(bus.at_thresh_o), 32'hf);
    chk_flags("reset", 4'b0000, 1'b0);

    //   tag    clear    up       step         down     counts {3,2,1,0}  thr      clip     irq
    cyc("c1",  4'b0000, 4'b0001, 8'b00000011, 4'b1110, 16'h888A, 4'b1111, 4'b0001, 1'b1); // ch0 9+3 saturates
    cyc("c2",  4'b0000, 4'b0001, 8'b00000011, 4'b1110, 16'h777A, 4'b0001, 4'b0001, 1'b1); // ch0 stays 10
    cyc("c3",  4'b0010, 4'b1010, 8'b01001000, 4'b0100, 16'h862A, 4'b1001, 4'b0001, 1'b1); // ch1 clear+up2, ch3 7->8
    cyc("c4",  4'b0001, 4'b0000, 8'b00000000, 4'b1100, 16'h7520, 4'b0000, 4'b0000, 1'b0); // ch0 clear, ch3 8->7
    cyc("c5",  4'b0001, 4'b0110, 8'b00010000, 4'b0101, 16'h7520, 4'b0000, 4'b0001, 1'b1); // ch2 +1-1, ch1 step0, ch0 clr+down
    cyc("c6",  4'b0001, 4'b0100, 8'b00000000, 4'b0100, 16'h7420, 4'b0000, 4'b0000, 1'b0); // ch2 step0+down
    cyc("c7",  4'b0000, 4'b0000, 8'b00000000, 4'b0100, 16'h7320, 4'b0000, 4'b0000, 1'b0);
    cyc("c8",  4'b0000, 4'b0000, 8'b00000000, 4'b0100, 16'h7220, 4'b0000, 4'b0000, 1'b0);
    cyc("c9",  4'b0000, 4'b0000, 8'b00000000, 4'b0100, 16'h7120, 4'b0000, 4'b0000, 1'b0);
    cyc("c10", 4'b0000, 4'b0000, 8'b00000000, 4'b0100, 16'h7020, 4'b0000, 4'b0000, 1'b0);
    cyc("c11", 4'b0000, 4'b1000, 8'b01000000, 4'b0100, 16'h8020, 4'b1000, 4'b0100, 1'b1); // ch2 floors at 0
    cyc("c12", 4'b0000, 4'b0010, 8'b00001100, 4'b1000, 16'h7050, 4'b0000, 4'b0100, 1'b1); // ch3 8->7, ch1 +3
    cyc("c13", 4'b0000, 4'b0011, 8'b00001111, 4'b0000, 16'h7083, 4'b0010, 4'b0100, 1'b1); // ch1 5->8, ch0 0->3

    // Asynchronous reset mid-operation, checked before any further clock edge.
    bus.up_i = 4'b1111;
    bus.up_step_i = 8'hff;
    #1;
    reset_n = 1'b0;
    #1;
    chk("areset.count",  32'(bus.count_o),     32'h9999);
    chk("areset.thresh", 32'(bus.at_thresh_o), 32'hf);
    chk_flags("areset", 4'b0000, 1'b0);
    @(negedge clk);
    bus.up_i = '0;
    bus.up_step_i = '0;
    reset_n = 1'b1;
    cyc("post", 4'b0000, 4'b0001, 8'b00000001, 4'b0010, 16'h998A, 4'b1111, 4'b0000, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
